gbtsca_cmd_seq: RTL and testbench
=================================

GBTSCA_CMD_SEQ -- requirements
Module: gbtsca_cmd_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20'd100000; maximum io_clk cycles spent polling for a reply.
REQ-002 SHALL have parameter POLL_GAP, default 8'd16; idle cycles between consecutive status polls.
REQ-003 SHALL have port io_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_b  in  1  synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 SHALL have port cmd_chan, cmd_cmd, cmd_tid, cmd_len  in  8 each  SCA channel, command, transaction ID, length.
REQ-007 SHALL have port cmd_data  in  32  SCA payload.
REQ-008 SHALL have port hdlc_addr  out  4  register address toward the HDLC manager.
REQ-009 SHALL have port hdlc_din  out  16  write data.
REQ-010 SHALL have port hdlc_we  out  1  write strobe.
REQ-011 SHALL have port hdlc_dout  in  16  read data (combinational function of hdlc_addr).
REQ-012 SHALL have port rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-013 SHALL have port rsp_data  out  32  reply payload.
REQ-014 SHALL have port rsp_err  out  8  reply error byte.
REQ-015 SHALL have port rsp_timeout, rsp_tid_mismatch  out  1 each  status flags.

Function
REQ-016 SHALL use this fixed register map: writes 0={tid,chan}, 1={len,cmd}, 2=data[15:0], 3=data[31:16], 7=din 16'h0001 (send); reads 8=status (bit0 = reply pending), 9={tid,chan}, A={err,len}, B=data lo, C=data hi; write F=din 16'h0001 (pop reply).
REQ-017 SHALL never drive hdlc_din bits 5 or 6 high during an address-7 write.
REQ-018 SHALL implement states IDLE, WRITE, SEND, GAP, POLL, READ, POP, RESP.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready SHALL latch all cmd_* fields and go to WRITE.
REQ-020 cmd_ready SHALL be 0 in every state except IDLE.
REQ-021 WRITE SHALL issue four single-cycle hdlc_we pulses on consecutive cycles, addresses 0,1,2,3, with latched data; then SEND.
REQ-022 SEND SHALL issue one hdlc_we pulse to address 7; clear timeout counter; go to GAP.
REQ-023 GAP SHALL wait POLL_GAP cycles, then go to POLL.
REQ-024 Each read SHALL take 2 cycles: addr presented in cycle 1 with hdlc_we=0, hdlc_dout sampled at end of cycle 2.
REQ-025 POLL SHALL read address 8; bit0=1 -> READ; bit0=0 -> GAP.
REQ-026 Timeout counter SHALL increment every cycle in GAP and POLL; on reaching TIMEOUT_CYCLES SHALL go to RESP with rsp_timeout=1, rsp_data=0, rsp_err=0, no pop.
REQ-027 READ SHALL read addresses 9, A, B, C in order (8 cycles), capture rsp_err from A[15:8], rsp_data from {C,B}.
REQ-028 rsp_tid_mismatch SHALL be 1 when read 9[15:8] != latched tid; reply still returned.
REQ-029 POP SHALL issue one hdlc_we pulse to address F, then go to RESP.
REQ-030 RESP: rsp_valid=1 with stable rsp_* until rsp_valid&&rsp_ready, then IDLE on the next cycle.
REQ-031 hdlc_we SHALL be 0 in every cycle not named in REQ-021/022/029.
REQ-032 Timeout compare SHALL be unsigned, counter width 20 bits, saturating; no wrap.

Reset
REQ-033 reset_b=0 at a clock edge SHALL force IDLE from any state, including mid-WRITE or mid-READ.
REQ-034 During reset: cmd_ready=0, hdlc_we=0, hdlc_addr=0, hdlc_din=0, rsp_valid=0, rsp_data=0, rsp_err=0, both flags 0, counters 0.
REQ-035 cmd_ready SHALL rise the first cycle after reset_b returns high.

Verification
REQ-036 Command chan=8'h02 cmd=8'h10 tid=8'h05 len=4 data=32'hDEADBEEF -> writes 0:0502, 1:0410, 2:BEEF, 3:DEAD, 7:0001 on 5 consecutive cycles.
REQ-037 Model reply pending after 3 polls, 9=0502, A=0004, B=1234, C=5678 -> rsp_data=32'h56781234, rsp_err=0, mismatch=0, one write F:0001.
REQ-038 Reply tid 8'h06 vs sent 8'h05 -> rsp_tid_mismatch=1, pop still issued.
REQ-039 Status bit0 never set, TIMEOUT_CYCLES=200 -> rsp_timeout=1 within 200+POLL_GAP+2 cycles of SEND; no address-F write.
REQ-040 rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0 throughout; second command accepted only after handshake.
REQ-041 reset_b low during READ -> next cycle hdlc_we=0, rsp_valid=0; after release, cmd_ready=1 and new command runs normally.

Source files
------------

// File: rtl/gbtsca_cmd_seq.sv
// GBT-SCA command sequencer: writes a command into the HDLC manager register file,
// polls for the reply, reads it back and presents it on a valid/ready response port.
module gbtsca_cmd_seq #(
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
   parameter logic [7:0]  POLL_GAP       = 8'd16
) (
   input  logic        io_clk,
   input  logic        reset_b,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_chan,
   input  logic [7:0]  cmd_cmd,
   input  logic [7:0]  cmd_tid,
   input  logic [7:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic [3:0]  hdlc_addr,
   output logic [15:0] hdlc_din,
   output logic        hdlc_we,
   input  logic [15:0] hdlc_dout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [7:0]  rsp_err,
   output logic        rsp_timeout,
   output logic        rsp_tid_mismatch
);

   typedef enum logic [2:0] {
      StIdle, StWrite, StSend, StGap, StPoll, StRead, StPop, StResp
   } state_e;

   state_e      r_state, w_state;
   logic [1:0]  r_idx, w_idx;
   logic        r_phase, w_phase;
   logic [7:0]  r_gap, w_gap;
   logic [19:0] r_tmo, w_tmo;
   logic [7:0]  r_chan, w_chan, r_cmd, w_cmd, r_tid, w_tid, r_len, w_len;
   logic [31:0] r_data, w_data;
   logic [31:0] r_rsp_data, w_rsp_data;
   logic [7:0]  r_rsp_err, w_rsp_err;
   logic        r_timeout, w_timeout;
   logic        r_mismatch, w_mismatch;

   logic        w_ready, w_we, w_valid;
   logic [3:0]  w_addr;
   logic [15:0] w_din;
   logic [19:0] w_tmo_inc;
   logic        w_tmo_hit, w_gap_done;

   always_ff @(posedge io_clk) begin
      if (!reset_b) begin
         r_state    <= StIdle;
         r_idx      <= '0;
         r_phase    <= 1'b0;
         r_gap      <= '0;
         r_tmo      <= '0;
         r_chan     <= '0;
         r_cmd      <= '0;
         r_tid      <= '0;
         r_len      <= '0;
         r_data     <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= '0;
         r_timeout  <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_idx      <= w_idx;
         r_phase    <= w_phase;
         r_gap      <= w_gap;
         r_tmo      <= w_tmo;
         r_chan     <= w_chan;
         r_cmd      <= w_cmd;
         r_tid      <= w_tid;
         r_len      <= w_len;
         r_data     <= w_data;
         r_rsp_data <= w_rsp_data;
         r_rsp_err  <= w_rsp_err;
         r_timeout  <= w_timeout;
         r_mismatch <= w_mismatch;
      end
   end

   // Counter saturates so a huge TIMEOUT_CYCLES can never be skipped by wrap-around.
   assign w_tmo_inc  = (r_tmo == 20'hFFFFF) ? r_tmo : r_tmo + 20'd1;
   assign w_tmo_hit  = (r_tmo >= TIMEOUT_CYCLES);
   assign w_gap_done = (({1'b0, r_gap} + 9'd1) >= {1'b0, POLL_GAP});

   always_comb begin
      w_state    = r_state;
      w_idx      = r_idx;
      w_phase    = r_phase;
      w_gap      = r_gap;
      w_tmo      = r_tmo;
      w_chan     = r_chan;
      w_cmd      = r_cmd;
      w_tid      = r_tid;
      w_len      = r_len;
      w_data     = r_data;
      w_rsp_data = r_rsp_data;
      w_rsp_err  = r_rsp_err;
      w_timeout  = r_timeout;
      w_mismatch = r_mismatch;
      w_ready    = 1'b0;
      w_we       = 1'b0;
      w_valid    = 1'b0;
      w_addr     = 4'h0;
      w_din      = 16'h0000;

      case (r_state)
         StIdle: begin
            w_ready = 1'b1;
            if (cmd_valid) begin
               w_chan     = cmd_chan;
               w_cmd      = cmd_cmd;
               w_tid      = cmd_tid;
               w_len      = cmd_len;
               w_data     = cmd_data;
               w_idx      = 2'd0;
               w_rsp_data = '0;
               w_rsp_err  = '0;
               w_timeout  = 1'b0;
               w_mismatch = 1'b0;
               w_state    = StWrite;
            end
         end
         StWrite: begin
            w_we   = 1'b1;
            w_addr = {2'b00, r_idx};
            case (r_idx)
               2'd0:    w_din = {r_tid, r_chan};
               2'd1:    w_din = {r_len, r_cmd};
               2'd2:    w_din = r_data[15:0];
               default: w_din = r_data[31:16];
            endcase
            w_idx = r_idx + 2'd1;
            if (r_idx == 2'd3) w_state = StSend;
         end
         StSend: begin
            w_we    = 1'b1;
            w_addr  = 4'h7;
            w_din   = 16'h0001;
            w_tmo   = '0;
            w_gap   = '0;
            w_state = StGap;
         end
         StGap: begin
            if (w_tmo_hit) begin
               w_timeout  = 1'b1;
               w_rsp_data = '0;
               w_rsp_err  = '0;
               w_state    = StResp;
            end else begin
               w_tmo = w_tmo_inc;
               if (w_gap_done) begin
                  w_phase = 1'b0;
                  w_state = StPoll;
               end else begin
                  w_gap = r_gap + 8'd1;
               end
            end
         end
         StPoll: begin
            w_addr = 4'h8;
            if (w_tmo_hit) begin
               w_timeout  = 1'b1;
               w_rsp_data = '0;
               w_rsp_err  = '0;
               w_state    = StResp;
            end else begin
               w_tmo   = w_tmo_inc;
               w_phase = ~r_phase;
               if (r_phase) begin
                  if (hdlc_dout[0]) begin
                     w_idx   = 2'd0;
                     w_state = StRead;
                  end else begin
                     w_gap   = '0;
                     w_state = StGap;
                  end
               end
            end
         end
         StRead: begin
            w_addr  = 4'h9 + {2'b00, r_idx};
            w_phase = ~r_phase;
            // Second cycle of each read: the register file output has settled.
            if (r_phase) begin
               case (r_idx)
                  2'd0:    w_mismatch = (hdlc_dout[15:8] != r_tid);
                  2'd1:    w_rsp_err = hdlc_dout[15:8];
                  2'd2:    w_rsp_data[15:0] = hdlc_dout;
                  default: w_rsp_data[31:16] = hdlc_dout;
               endcase
               w_idx = r_idx + 2'd1;
               if (r_idx == 2'd3) w_state = StPop;
            end
         end
         StPop: begin
            w_we    = 1'b1;
            w_addr  = 4'hF;
            w_din   = 16'h0001;
            w_state = StResp;
         end
         StResp: begin
            w_valid = 1'b1;
            if (rsp_ready) w_state = StIdle;
         end
         default: w_state = StIdle;
      endcase
   end

   // Gate with reset_b so every output is quiet for the whole time reset is held.
   assign cmd_ready        = reset_b & w_ready;
   assign hdlc_we          = reset_b & w_we;
   assign hdlc_addr        = reset_b ? w_addr : 4'h0;
   assign hdlc_din         = reset_b ? w_din : 16'h0000;
   assign rsp_valid        = reset_b & w_valid;
   assign rsp_data         = reset_b ? r_rsp_data : 32'h0;
   assign rsp_err          = reset_b ? r_rsp_err : 8'h00;
   assign rsp_timeout      = reset_b & r_timeout;
   assign rsp_tid_mismatch = reset_b & r_mismatch;

endmodule

// File: tb/tb_gbtsca_cmd_seq.sv
// Directed bench for gbtsca_cmd_seq with a behavioural HDLC register-file model.
module tb_gbtsca_cmd_seq;

   logic        io_clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_chan = '0, cmd_cmd = '0, cmd_tid = '0, cmd_len = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  hdlc_addr;
   logic [15:0] hdlc_din;
   logic        hdlc_we;
   logic [15:0] hdlc_dout;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [7:0]  rsp_err;
   logic        rsp_timeout, rsp_tid_mismatch;

   int n_checks = 0;
   int n_errors = 0;

   logic        stat_en = 1'b0;
   int          polls_needed = 3;
   logic [15:0] m_r9 = 16'h0502, m_ra = 16'h0004, m_rb = 16'h1234, m_rc = 16'h5678;

   int          cyc = 0;
   int          poll_cycles = 0;
   int          bad56 = 0;
   logic [3:0]  wr_addr[$];
   logic [15:0] wr_din[$];
   int          wr_cyc[$];

   gbtsca_cmd_seq #(
      .TIMEOUT_CYCLES(20'd200),
      .POLL_GAP      (8'd16)
   ) dut (
      .io_clk          (io_clk),
      .reset_b         (reset_b),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_chan        (cmd_chan),
      .cmd_cmd         (cmd_cmd),
      .cmd_tid         (cmd_tid),
      .cmd_len         (cmd_len),
      .cmd_data        (cmd_data),
      .hdlc_addr       (hdlc_addr),
      .hdlc_din        (hdlc_din),
      .hdlc_we         (hdlc_we),
      .hdlc_dout       (hdlc_dout),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .rsp_timeout     (rsp_timeout),
      .rsp_tid_mismatch(rsp_tid_mismatch)
   );

   always #5 io_clk = ~io_clk;

   // Reply becomes pending once polls_needed complete polls have read status 0.
   always_comb begin
      hdlc_dout = 16'h0000;
      case (hdlc_addr)
         4'h8: hdlc_dout = {15'h0, stat_en && (poll_cycles >= 2 * polls_needed)};
         4'h9: hdlc_dout = m_r9;
         4'hA: hdlc_dout = m_ra;
         4'hB: hdlc_dout = m_rb;
         4'hC: hdlc_dout = m_rc;
         default: hdlc_dout = 16'h0000;
      endcase
   end

   always @(posedge io_clk) begin
      cyc <= cyc + 1;
      if (reset_b && hdlc_we) begin
         wr_addr.push_back(hdlc_addr);
         wr_din.push_back(hdlc_din);
         wr_cyc.push_back(cyc);
      end
      if (hdlc_we && hdlc_addr == 4'h7) poll_cycles <= 0;
      else if (!hdlc_we && hdlc_addr == 4'h8) poll_cycles <= poll_cycles + 1;
      if (hdlc_we && hdlc_addr == 4'h7 && (hdlc_din[5] || hdlc_din[6])) bad56 <= bad56 + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic issue_cmd(input logic [7:0] chan, input logic [7:0] cmd,
                            input logic [7:0] tid, input logic [7:0] len,
                            input logic [31:0] data, output bit ok);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge io_clk);
         n++;
      end
      ok = (cmd_ready === 1'b1);
      cmd_chan = chan; cmd_cmd = cmd; cmd_tid = tid; cmd_len = len; cmd_data = data;
      cmd_valid = 1'b1;
      @(negedge io_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 1000) begin
         @(negedge io_clk);
         n++;
      end
      ok = (rsp_valid === 1'b1);
   endtask

   task automatic do_handshake;
      rsp_ready = 1'b1;
      @(negedge io_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset_b = 1'b0;
      repeat (3) @(negedge io_clk);
      n_checks++;
      if ({cmd_ready, hdlc_we, hdlc_addr, hdlc_din, rsp_valid, rsp_data, rsp_err,
           rsp_timeout, rsp_tid_mismatch} !== 64'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h din=%h v=%b d=%h e=%h t=%b m=%b want all 0",
                  cmd_ready, hdlc_we, hdlc_addr, hdlc_din, rsp_valid, rsp_data, rsp_err,
                  rsp_timeout, rsp_tid_mismatch);
      end
      reset_b = 1'b1;
      @(negedge io_clk);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_nominal;
      logic [3:0]  ea[6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};
      logic [15:0] ed[6] = '{16'h0502, 16'h0410, 16'hBEEF, 16'hDEAD, 16'h0001, 16'h0001};
      int base = wr_addr.size();
      bit ok;
      stat_en = 1'b1; polls_needed = 3;
      m_r9 = 16'h0502; m_ra = 16'h0004; m_rb = 16'h1234; m_rc = 16'h5678;
      issue_cmd(8'h02, 8'h10, 8'h05, 8'h04, 32'hDEADBEEF, ok);
      wait_rsp(ok);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL nom_rsp_valid: got %b want 1", rsp_valid);
      end
      n_checks++;
      if ({rsp_data, rsp_err, rsp_timeout, rsp_tid_mismatch, cmd_ready} !== {32'h56781234, 8'h00, 3'b000}) begin
         n_errors++;
         $display("FAIL nom_rsp: got data=%h err=%h t=%b m=%b rdy=%b want 56781234 00 0 0 0",
                  rsp_data, rsp_err, rsp_timeout, rsp_tid_mismatch, cmd_ready);
      end
      do_handshake();
      n_checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL nom_after_hs: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
      end
      n_checks++;
      if (wr_addr.size() - base != 6) begin
         n_errors++;
         $display("FAIL nom_write_count: got %0d want 6", wr_addr.size() - base);
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (wr_addr[base + k] !== ea[k] || wr_din[base + k] !== ed[k]) begin
               n_errors++;
               $display("FAIL nom_write%0d: got %h:%h want %h:%h", k, wr_addr[base + k],
                        wr_din[base + k], ea[k], ed[k]);
            end
         end
         n_checks++;
         if (wr_cyc[base + 4] - wr_cyc[base] != 4) begin
            n_errors++;
            $display("FAIL nom_write_consecutive: got span %0d want 4", wr_cyc[base + 4] - wr_cyc[base]);
         end
         // 4 x (16 gap + 2 poll) + 8 read + 1 pop cycles after send.
         n_checks++;
         if (wr_cyc[base + 5] - wr_cyc[base + 4] != 81) begin
            n_errors++;
            $display("FAIL nom_send_to_pop: got %0d want 81", wr_cyc[base + 5] - wr_cyc[base + 4]);
         end
      end
      n_checks++;
      if (poll_cycles != 8 || bad56 != 0) begin
         n_errors++;
         $display("FAIL nom_polls: got poll_cycles=%0d bad56=%0d want 8 0", poll_cycles, bad56);
      end
   endtask

   task automatic test_mismatch;
      int base = wr_addr.size();
      bit ok;
      stat_en = 1'b1; m_r9 = 16'h0602;
      issue_cmd(8'h02, 8'h10, 8'h05, 8'h04, 32'hDEADBEEF, ok);
      wait_rsp(ok);
      n_checks++;
      if (!ok || rsp_tid_mismatch !== 1'b1 || rsp_data !== 32'h56781234 || rsp_timeout !== 1'b0) begin
         n_errors++;
         $display("FAIL mismatch_rsp: got v=%b m=%b data=%h t=%b want 1 1 56781234 0",
                  rsp_valid, rsp_tid_mismatch, rsp_data, rsp_timeout);
      end
      n_checks++;
      if (wr_addr.size() - base != 6 || wr_addr[wr_addr.size() - 1] !== 4'hF) begin
         n_errors++;
         $display("FAIL mismatch_pop: got %0d writes, last addr %h want 6 F",
                  wr_addr.size() - base, wr_addr[wr_addr.size() - 1]);
      end
      do_handshake();
      m_r9 = 16'h0502;
   endtask

   task automatic test_timeout;
      int base = wr_addr.size();
      int elapsed;
      bit ok;
      stat_en = 1'b0;
      issue_cmd(8'h01, 8'h20, 8'h09, 8'h01, 32'h00000042, ok);
      wait_rsp(ok);
      n_checks++;
      if (!ok || {rsp_timeout, rsp_data, rsp_err, rsp_tid_mismatch} !== {1'b1, 41'h0}) begin
         n_errors++;
         $display("FAIL timeout_rsp: got v=%b t=%b data=%h err=%h m=%b want 1 1 0 0 0",
                  rsp_valid, rsp_timeout, rsp_data, rsp_err, rsp_tid_mismatch);
      end
      n_checks++;
      if (wr_addr.size() - base != 5) begin
         n_errors++;
         $display("FAIL timeout_no_pop: got %0d writes want 5", wr_addr.size() - base);
      end else begin
         elapsed = cyc - wr_cyc[base + 4];
         n_checks++;
         if (elapsed < 200 || elapsed > 218) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d cycles want 200..218", elapsed);
         end
      end
      do_handshake();
      stat_en = 1'b1;
   endtask

   task automatic test_back_to_back;
      int base1;
      bit ok;
      stat_en = 1'b1; m_r9 = 16'h0502;
      issue_cmd(8'h02, 8'h10, 8'h05, 8'h04, 32'hDEADBEEF, ok);
      wait_rsp(ok);
      base1 = wr_addr.size();
      cmd_chan = 8'h03; cmd_cmd = 8'h11; cmd_tid = 8'h07; cmd_len = 8'h04;
      cmd_data = 32'hCAFEF00D; cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h56781234 || rsp_err !== 8'h00 ||
             rsp_tid_mismatch !== 1'b0 || cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stall%0d: got v=%b data=%h err=%h m=%b rdy=%b want 1 56781234 00 0 0",
                     i, rsp_valid, rsp_data, rsp_err, rsp_tid_mismatch, cmd_ready);
         end
         @(negedge io_clk);
      end
      do_handshake();
      n_checks++;
      if (cmd_ready !== 1'b1 || wr_addr.size() != base1) begin
         n_errors++;
         $display("FAIL b2b_idle: got rdy=%b writes=%0d want 1 %0d", cmd_ready, wr_addr.size(), base1);
      end
      @(negedge io_clk);
      cmd_valid = 1'b0;
      wait_rsp(ok);
      n_checks++;
      if (!ok || rsp_tid_mismatch !== 1'b1 || rsp_data !== 32'h56781234) begin
         n_errors++;
         $display("FAIL b2b_second_rsp: got v=%b m=%b data=%h want 1 1 56781234",
                  rsp_valid, rsp_tid_mismatch, rsp_data);
      end
      n_checks++;
      if (wr_addr.size() - base1 != 6 || wr_din[base1] !== 16'h0703 || wr_din[base1 + 3] !== 16'hCAFE) begin
         n_errors++;
         $display("FAIL b2b_second_writes: got n=%0d w0=%h w3=%h want 6 0703 CAFE",
                  wr_addr.size() - base1, wr_din[base1], wr_din[base1 + 3]);
      end
      do_handshake();
   endtask

   task automatic test_reset_mid_read;
      int n = 0;
      int base;
      bit ok;
      stat_en = 1'b1; m_r9 = 16'h0502; m_rb = 16'h9ABC; m_rc = 16'hDEF0;
      issue_cmd(8'h02, 8'h10, 8'h05, 8'h04, 32'hDEADBEEF, ok);
      while (hdlc_addr !== 4'hA && n < 500) begin
         @(negedge io_clk);
         n++;
      end
      n_checks++;
      if (hdlc_addr !== 4'hA) begin
         n_errors++;
         $display("FAIL rst_read_reach: got addr %h want A", hdlc_addr);
      end
      reset_b = 1'b0;
      @(negedge io_clk);
      n_checks++;
      if (hdlc_we !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || hdlc_addr !== 4'h0) begin
         n_errors++;
         $display("FAIL rst_read_outputs: got we=%b v=%b rdy=%b addr=%h want 0 0 0 0",
                  hdlc_we, rsp_valid, cmd_ready, hdlc_addr);
      end
      reset_b = 1'b1;
      @(negedge io_clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_read_release: got rdy=%b v=%b want 1 0", cmd_ready, rsp_valid);
      end
      base = wr_addr.size();
      issue_cmd(8'h04, 8'h12, 8'h05, 8'h02, 32'h11112222, ok);
      wait_rsp(ok);
      n_checks++;
      if (!ok || rsp_data !== 32'hDEF09ABC || rsp_tid_mismatch !== 1'b0 || rsp_timeout !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_new_rsp: got v=%b data=%h m=%b t=%b want 1 DEF09ABC 0 0",
                  rsp_valid, rsp_data, rsp_tid_mismatch, rsp_timeout);
      end
      n_checks++;
      if (wr_addr.size() - base != 6 || wr_din[base] !== 16'h0504 || wr_din[base + 1] !== 16'h0212) begin
         n_errors++;
         $display("FAIL rst_new_writes: got n=%0d w0=%h w1=%h want 6 0504 0212",
                  wr_addr.size() - base, wr_din[base], wr_din[base + 1]);
      end
      do_handshake();
   endtask

   initial begin
      @(negedge io_clk);
      test_reset();
      test_nominal();
      test_mismatch();
      test_timeout();
      test_back_to_back();
      test_reset_mid_read();
      n_checks++;
      if (bad56 != 0) begin
         n_errors++;
         $display("FAIL send_din_bits56: got %0d bad sends want 0", bad56);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
